imem_loader: RTL and testbench
==============================

# imem_loader

Instruction-memory controller for the single-cycle CPU. It owns a byte-wide instruction store and arbitrates it between a byte-stream program loader (valid/ready) and the CPU fetch port. It holds the CPU in stall until a program image has been loaded. Fetch is big-endian and combinational; loading is sequential, one byte per accepted handshake.

## Interface
- MEM_BYTES, 256, instruction store size in bytes; must be a power of two and a multiple of 4.
- ADDR_W, 8, log2(MEM_BYTES).
- HALT_WORD, 32'hFC000000, word returned on stalled, misaligned or out-of-range fetch.

Clock and reset are decided: one clock; reset is synchronous and active-high.

- CLK, in, 1, clock; all state updates on the rising edge.
- Reset, in, 1, synchronous, active-high reset.
- LoadStart, in, 1, single-cycle request to begin a load.
- LoadLen, in, ADDR_W+1, image length in bytes; sampled only with LoadStart.
- ByteValid, in, 1, loader byte present.
- ByteData, in, 8, loader byte.
- ByteReady, out, 1, controller accepts a byte this cycle.
- InstructAddress, in, 32, CPU fetch byte address.
- Instruction, out, 32, fetched word.
- CpuStall, out, 1, CPU must not advance its PC.
- LoadDone, out, 1, one-cycle pulse when the last byte is written.
- LoadErr, out, 1, one-cycle pulse when a LoadStart is rejected.
- LoadCount, out, ADDR_W+1, bytes written in the current or last load.

## Operation
- States:
  - HALT: after reset.
  - LOAD
  - RUN
- Reset:
  - State goes to HALT.
  - LoadCount, sampled length, LoadDone and LoadErr are cleared to 0.
  - The store is not cleared; it keeps its contents.
- HALT or RUN with LoadStart=1:
  - If LoadLen==0, or LoadLen[1:0]!=0, or LoadLen>MEM_BYTES: pulse LoadErr and stay in the current state.
  - Otherwise: latch LoadLen, set LoadCount=0, go to LOAD.
- LOAD:
  - ByteReady=1.
  - A byte is accepted when ByteValid && ByteReady.
  - On acceptance: Store[LoadCount]<=ByteData and LoadCount<=LoadCount+1.
  - When the accepted byte is number latched_len-1: go to RUN and pulse LoadDone.
  - LoadStart is ignored while in LOAD; no LoadErr is raised.
- ByteReady=0 in HALT and RUN. ByteValid there is ignored, and the byte is not consumed.
- CpuStall=1 in HALT and LOAD; CpuStall=0 in RUN.
- Fetch, purely combinational, returns {Store[A], Store[A+1], Store[A+2], Store[A+3]} where A=InstructAddress.
- Instruction=HALT_WORD when any of the following holds:
  - CpuStall=1
  - InstructAddress[1:0]!=0
  - InstructAddress>MEM_BYTES-4, with the full 32-bit compare; no address wrap.
- Loaded bytes beyond latched_len keep their previous contents. Fetch in RUN returns them unchanged.

## Timing
- Write latency: a byte accepted in cycle N is visible on Instruction in cycle N+1.
- Completion: if the last byte is accepted in cycle N, then in cycle N+1:
  - State is RUN.
  - CpuStall=0.
  - LoadDone=1.
  - ByteReady=0.
  - The full image is fetchable.
- LoadStart in cycle N: in cycle N+1, ByteReady=1 and CpuStall=1. This also holds when coming from RUN, where CpuStall re-asserts.
- LoadErr is asserted in cycle N+1 for a rejected LoadStart in cycle N, and lasts one cycle.
- ByteReady is registered and depends on state only, never on ByteValid.
- Reset during LOAD:
  - Next cycle the state is HALT, ByteReady=0, CpuStall=1 and LoadCount=0.
  - Partially written bytes remain in the store.
- Reset takes priority over LoadStart and over byte acceptance in the same cycle.
- Back-to-back bytes are accepted every cycle: throughput is 1 byte/cycle.

## Structure
- Shared package:
  - State encoding: HALT=2'd0, LOAD=2'd1, RUN=2'd2.
  - HALT_WORD default.
- One sub-module, imem_byte_ram:
  - Storage array with 1 synchronous byte write port and 4 combinational byte read ports.
  - Read addresses A..A+3.
  - Optional $readmemb initialisation, so the CPU can boot without a load when the FSM is forced to RUN in simulation.
- Top level: FSM, counter, length check, fetch mux.

## Test plan
- Reset, then fetch address 0 → Instruction=32'hFC000000, CpuStall=1, ByteReady=0.
- LoadStart with LoadLen=8, then bytes 8'h02,8'h21,8'h00,8'h01,8'h02,8'h22,8'h00,8'h03 on consecutive cycles:
  - LoadDone pulses one cycle after the 8th byte.
  - CpuStall=0.
  - Fetch 0 → 32'h02210001.
  - Fetch 4 → 32'h02220003.
- LoadLen values 0, 6 and 260 (with MEM_BYTES=256) → each gives a LoadErr pulse, state unchanged and ByteReady=0.
- ByteValid toggled 1,0,1,0 during a 4-byte load → exactly 4 writes, LoadCount=4, and no byte lost or duplicated.
- Reset asserted after 3 of 8 bytes → HALT next cycle with LoadCount=0. Then a fresh 4-byte load succeeds.
- In RUN:
  - Fetch 2 → HALT_WORD.
  - Fetch 252 → valid word.
  - Fetch 253 → HALT_WORD.
  - Fetch 32'h00000100 → HALT_WORD.
  - LoadStart in RUN → CpuStall re-asserts the next cycle.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding and the
// default word handed to the CPU when no valid instruction can be fetched.
package imem_loader_pkg;

    typedef enum logic [1:0] {
        S_HALT = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    localparam logic [31:0] HALT_WORD_DEF = 32'hFC000000;

    // A load length is usable when non-zero, word-aligned and no larger than the store.
    function automatic logic len_is_valid(input int unsigned len, input int unsigned mem_bytes);
        return (len != 0) && (len[1:0] == 2'b00) && (len <= mem_bytes);
    endfunction

endpackage

// File: rtl/imem_loader_byte_ram.sv
// Byte-wide instruction store: one synchronous write port and four
// combinational read ports returning the big-endian word at raddr..raddr+3.
module imem_loader_byte_ram #(
    parameter int MEM_BYTES = 256,
    parameter int ADDR_W    = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rword
);

    logic [7:0] mem [MEM_BYTES];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Byte gi of the word sits in the most significant lane first; the
    // read address wraps in the store and out-of-range words are masked above.
    for (genvar gi = 0; gi < 4; gi++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        assign ra = raddr + ADDR_W'(gi);
        assign rword[31-8*gi -: 8] = mem[ra];
    end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory controller: loads a program image one byte per
// handshake, then releases the CPU and serves big-endian combinational fetches.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          MEM_BYTES = 256,
    parameter int          ADDR_W    = 8,
    parameter logic [31:0] HALT_WORD = HALT_WORD_DEF
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              LoadStart,
    input  logic [ADDR_W:0]   LoadLen,
    input  logic              ByteValid,
    input  logic [7:0]        ByteData,
    output logic              ByteReady,
    input  logic [31:0]       InstructAddress,
    output logic [31:0]       Instruction,
    output logic              CpuStall,
    output logic              LoadDone,
    output logic              LoadErr,
    output logic [ADDR_W:0]   LoadCount
);

    localparam logic [31:0] LAST_WORD_ADDR = 32'(MEM_BYTES - 4);

    state_t          state_reg, state_next;
    logic            ready_reg;
    logic [ADDR_W:0] count_reg;
    logic [ADDR_W:0] len_reg;
    logic            done_reg;
    logic            err_reg;

    logic            len_ok;
    logic            start_ok;
    logic            start_bad;
    logic            accept;
    logic            last_byte;
    logic [31:0]     ram_word;

    assign len_ok    = len_is_valid(32'(LoadLen), MEM_BYTES);
    assign start_ok  = LoadStart && (state_reg != S_LOAD) && len_ok;
    assign start_bad = LoadStart && (state_reg != S_LOAD) && !len_ok;
    assign accept    = ready_reg && ByteValid && (state_reg == S_LOAD);
    assign last_byte = accept && ((count_reg + (ADDR_W+1)'(1)) == len_reg);

    // Reset wins over a byte arriving in the same cycle: that byte is dropped.
    imem_loader_byte_ram #(
        .MEM_BYTES (MEM_BYTES),
        .ADDR_W    (ADDR_W)
    ) u_ram (
        .clk   (CLK),
        .we    (accept && !Reset),
        .waddr (count_reg[ADDR_W-1:0]),
        .wdata (ByteData),
        .raddr (InstructAddress[ADDR_W-1:0]),
        .rword (ram_word)
    );

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_reg <= S_HALT;
            ready_reg <= 1'b0;
            count_reg <= '0;
            len_reg   <= '0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            ready_reg <= (state_next == S_LOAD);
            done_reg  <= last_byte;
            err_reg   <= start_bad;
            if (start_ok) begin
                len_reg   <= LoadLen;
                count_reg <= '0;
            end else if (accept) begin
                count_reg <= count_reg + (ADDR_W+1)'(1);
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_HALT, S_RUN: if (start_ok) state_next = S_LOAD;
            S_LOAD:        if (last_byte) state_next = S_RUN;
            default:       state_next = S_HALT;
        endcase
    end

    always_comb begin
        ByteReady   = ready_reg;
        CpuStall    = (state_reg != S_RUN);
        LoadDone    = done_reg;
        LoadErr     = err_reg;
        LoadCount   = count_reg;
        Instruction = HALT_WORD;
        if (!CpuStall && (InstructAddress[1:0] == 2'b00) && (InstructAddress <= LAST_WORD_ADDR)) begin
            Instruction = ram_word;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus queues expected observations,
// a negedge monitor pops and compares them along with LoadDone/LoadErr pulses.
module tb_imem_loader;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic        LoadStart = 1'b0;
    logic [8:0]  LoadLen = '0;
    logic        ByteValid = 1'b0;
    logic [7:0]  ByteData = '0;
    logic        ByteReady;
    logic [31:0] InstructAddress = '0;
    logic [31:0] Instruction;
    logic        CpuStall;
    logic        LoadDone;
    logic        LoadErr;
    logic [8:0]  LoadCount;

    always #5 CLK = ~CLK;

    imem_loader #(
        .MEM_BYTES (256),
        .ADDR_W    (8),
        .HALT_WORD (32'hFC000000)
    ) dut (
        .CLK             (CLK),
        .Reset           (Reset),
        .LoadStart       (LoadStart),
        .LoadLen         (LoadLen),
        .ByteValid       (ByteValid),
        .ByteData        (ByteData),
        .ByteReady       (ByteReady),
        .InstructAddress (InstructAddress),
        .Instruction     (Instruction),
        .CpuStall        (CpuStall),
        .LoadDone        (LoadDone),
        .LoadErr         (LoadErr),
        .LoadCount       (LoadCount)
    );

    typedef struct {
        string       name;
        int          at;
        logic [31:0] instr;
        logic        stall;
        logic        ready;
        logic [8:0]  count;
    } exp_t;

    exp_t q[$];
    int   done_q[$];
    int   err_q[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_now(input string n, input logic [31:0] i, input logic s,
                              input logic r, input logic [8:0] c);
        exp_t e;
        e.name  = n;
        e.at    = cyc;
        e.instr = i;
        e.stall = s;
        e.ready = r;
        e.count = c;
        q.push_back(e);
    endtask

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", n, act, req, cyc);
        end else begin
            $display("ok   %s value=%h (cycle %0d)", n, act, cyc);
        end
    endtask

    // Monitor: compares queued observations and every LoadDone/LoadErr pulse.
    always @(negedge CLK) begin
        while (q.size() > 0 && q[0].at <= cyc) begin
            exp_t e;
            e = q.pop_front();
            if (e.at != cyc) begin
                total++;
                bad++;
                $display("FAIL %s missed actual_cycle=%0d required_cycle=%0d", e.name, cyc, e.at);
            end else begin
                chk({e.name, ".instr"}, Instruction, e.instr);
                chk({e.name, ".stall"}, 32'(CpuStall), 32'(e.stall));
                chk({e.name, ".ready"}, 32'(ByteReady), 32'(e.ready));
                chk({e.name, ".count"}, 32'(LoadCount), 32'(e.count));
            end
        end
        if (LoadDone === 1'b1) begin
            if (done_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL done_unexpected actual=1 required=0 (cycle %0d)", cyc);
            end else begin
                chk("done_cycle", 32'(cyc), 32'(done_q.pop_front()));
            end
        end
        if (LoadErr === 1'b1) begin
            if (err_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL err_unexpected actual=1 required=0 (cycle %0d)", cyc);
            end else begin
                chk("err_cycle", 32'(cyc), 32'(err_q.pop_front()));
            end
        end
    end

    task automatic start_load(input logic [8:0] len);
        LoadStart = 1'b1;
        LoadLen   = len;
        tick();
        LoadStart = 1'b0;
    endtask

    task automatic start_bad(input logic [8:0] len);
        LoadStart = 1'b1;
        LoadLen   = len;
        err_q.push_back(cyc + 1);
        tick();
        LoadStart = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input bit is_last);
        ByteValid = 1'b1;
        ByteData  = d;
        if (is_last) done_q.push_back(cyc + 1);
        tick();
        ByteValid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] img8 [8];
        logic [7:0] tog_data [8];
        bit         tog_valid [8];
        int         nvalid;
        img8 = '{8'h02, 8'h21, 8'h00, 8'h01, 8'h02, 8'h22, 8'h00, 8'h03};
        tog_valid = '{1, 0, 1, 0, 1, 0, 1, 0};
        tog_data  = '{8'hA0, 8'hEE, 8'hA1, 8'hEE, 8'hA2, 8'hEE, 8'hA3, 8'hEE};

        // Reset state
        tick();
        tick();
        Reset = 1'b0;
        InstructAddress = 32'd0;
        expect_now("reset", 32'hFC000000, 1'b1, 1'b0, 9'd0);

        // 8-byte load
        start_load(9'd8);
        expect_now("load8_start", 32'hFC000000, 1'b1, 1'b1, 9'd0);
        for (int i = 0; i < 8; i++) send_byte(img8[i], i == 7);
        expect_now("load8_fetch0", 32'h02210001, 1'b0, 1'b0, 9'd8);
        tick();
        InstructAddress = 32'd4;
        expect_now("load8_fetch4", 32'h02220003, 1'b0, 1'b0, 9'd8);
        tick();

        // Rejected lengths in RUN
        start_bad(9'd0);
        expect_now("err_len0", 32'h02220003, 1'b0, 1'b0, 9'd8);
        start_bad(9'd6);
        expect_now("err_len6", 32'h02220003, 1'b0, 1'b0, 9'd8);
        start_bad(9'd260);
        expect_now("err_len260", 32'h02220003, 1'b0, 1'b0, 9'd8);
        tick();

        // 4-byte load with ByteValid toggling
        start_load(9'd4);
        nvalid = 0;
        for (int i = 0; i < 8; i++) begin
            ByteValid = tog_valid[i];
            ByteData  = tog_data[i];
            if (tog_valid[i]) begin
                nvalid++;
                if (nvalid == 4) done_q.push_back(cyc + 1);
            end
            tick();
        end
        ByteValid = 1'b0;
        InstructAddress = 32'd0;
        expect_now("toggle_fetch0", 32'hA0A1A2A3, 1'b0, 1'b0, 9'd4);
        tick();
        InstructAddress = 32'd4;
        expect_now("toggle_keep4", 32'h02220003, 1'b0, 1'b0, 9'd4);
        tick();

        // Reset after 3 of 8 bytes; a byte offered with reset must not land
        start_load(9'd8);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        Reset = 1'b1;
        ByteValid = 1'b1;
        ByteData = 8'h44;
        tick();
        Reset = 1'b0;
        ByteValid = 1'b0;
        expect_now("reset_midload", 32'hFC000000, 1'b1, 1'b0, 9'd0);
        start_bad(9'd6);
        expect_now("err_in_halt", 32'hFC000000, 1'b1, 1'b0, 9'd0);

        // Fresh 4-byte load; LoadStart during LOAD must be ignored silently
        start_load(9'd4);
        send_byte(8'hC0, 0);
        LoadStart = 1'b1;
        LoadLen = 9'd0;
        send_byte(8'hC1, 0);
        LoadStart = 1'b0;
        send_byte(8'hC2, 0);
        send_byte(8'hC3, 1);
        InstructAddress = 32'd0;
        expect_now("fresh_fetch0", 32'hC0C1C2C3, 1'b0, 1'b0, 9'd4);
        tick();
        InstructAddress = 32'd4;
        expect_now("fresh_fetch4", 32'h02220003, 1'b0, 1'b0, 9'd4);
        tick();

        // Full-store load, then address boundaries
        start_load(9'd256);
        for (int i = 0; i < 256; i++) send_byte(8'(i) ^ 8'h5A, i == 255);
        InstructAddress = 32'd0;
        expect_now("full_fetch0", 32'h5A5B5859, 1'b0, 1'b0, 9'd256);
        tick();
        InstructAddress = 32'd252;
        expect_now("fetch252", 32'hA6A7A4A5, 1'b0, 1'b0, 9'd256);
        tick();
        InstructAddress = 32'd2;
        expect_now("fetch2", 32'hFC000000, 1'b0, 1'b0, 9'd256);
        tick();
        InstructAddress = 32'd253;
        expect_now("fetch253", 32'hFC000000, 1'b0, 1'b0, 9'd256);
        tick();
        InstructAddress = 32'h00000100;
        expect_now("fetch256", 32'hFC000000, 1'b0, 1'b0, 9'd256);
        tick();
        InstructAddress = 32'hFFFFFFFC;
        expect_now("fetch_nowrap", 32'hFC000000, 1'b0, 1'b0, 9'd256);
        tick();

        // LoadStart from RUN re-asserts the stall
        InstructAddress = 32'd0;
        start_load(9'd4);
        expect_now("run_restart", 32'hFC000000, 1'b1, 1'b1, 9'd0);
        for (int i = 0; i < 4; i++) send_byte(8'h10 + 8'(i), i == 3);
        expect_now("restart_fetch0", 32'h10111213, 1'b0, 1'b0, 9'd4);

        repeat (3) tick();
        if (q.size() > 0 || done_q.size() > 0 || err_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL leftover actual=%0d required=0", q.size() + done_q.size() + err_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
